cpu_stream_collector: RTL and testbench
=======================================

# cpu_stream_collector

Server-side collector for the xorshift CPU-client streams. Each CPU client emits one 64-bit xorshift64 word per cycle while its valid is high and never accepts backpressure. This block checks every word on arrival against a per-channel reference xorshift64 model and buffers it in a per-channel FIFO. It then merges all channels round-robin onto a single valid/ready output stream tagged with the source CPU index, and keeps error, word and overflow status for the testbench or server.

## Interface
- NUM_CPUS, 4, number of client channels (1..16)
- FIFO_DEPTH, 8, words per channel FIFO (power of two, >= 2)
- SEED_BASE, 64'h1, xorshift seed of channel i is SEED_BASE + i (nonzero)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of status, FIFOs and reference models
- in_vld  in  NUM_CPUS  per-channel word strobe, bit i = CPU i
- in_data  in  64*NUM_CPUS  channel i word in bits [64*i+63:64*i]
- out_vld  out  1  merged output word valid
- out_rdy  in  1  downstream ready
- out_data  out  64  merged output word
- out_idx  out  4  source CPU index of out_data
- err_cnt  out  16  total mismatching words, saturating
- word_cnt  out  32  total output handshakes, wrapping
- overflow  out  NUM_CPUS  sticky, bit i set when channel i dropped a word

## Operation
- Reference model per channel: state s_i, reset/clr value SEED_BASE + i. Expected word is next(s_i), where next(x): x ^= x<<13; x ^= x>>7; x ^= x<<17 (all 64-bit, truncating).
- Each cycle with in_vld[i]=1: compare in_data_i with next(s_i), then set s_i <= next(s_i). The model advances on every valid word, including mismatched and dropped words, so one corrupt word causes exactly one error.
- err_cnt += number of channels mismatching this cycle. The result saturates at 16'hFFFF.
- FIFO write: in_vld[i]=1 and FIFO i not full gives a write. If FIFO i is full, the word is dropped and overflow[i] <= 1. Fullness is judged on occupancy before this cycle's pop, so a push to a full FIFO is dropped even when the same cycle pops it.
- Arbiter: round-robin pointer rr, reset 0. The candidate is the first non-empty FIFO at or after rr, wrapping modulo NUM_CPUS. On a pop from channel g, rr <= (g+1) mod NUM_CPUS. rr is unchanged when nothing is popped.
- Output register: loads the candidate (data, idx) and pops its FIFO when a candidate exists and (out_vld=0 or out_rdy=1).
- When out_vld=1 and out_rdy=1 with no candidate, out_vld <= 0.
- While out_vld=1 and out_rdy=0, out_data and out_idx are held stable.
- word_cnt increments on every out_vld&&out_rdy cycle and wraps at 2^32.
- clr=1 does all of the following in that cycle:
  - empties FIFOs, drops out_vld, and sets rr to 0;
  - zeroes err_cnt, word_cnt and overflow;
  - reloads every s_i.
  - Inputs presented in a clr cycle are ignored.

## Timing
- Reset (rst_n=0, async) sets all of the following:
  - out_vld=0, out_data=0, out_idx=0;
  - err_cnt=0, word_cnt=0, overflow=0;
  - FIFOs empty, rr=0, s_i=SEED_BASE+i.
- Reset mid-stream discards buffered words with no partial output. out_vld falls immediately (async).
- Latency: a word sampled at edge k into an empty FIFO, with the output register free, is on out_data with out_vld=1 after edge k+1.
- err_cnt reflects a mismatch sampled at edge k after edge k.
- Throughput: one output word per cycle while out_rdy=1. Aggregate input above 1 word/cycle accumulates in the FIFOs.
- FIFO occupancy: FIFO_DEPTH words, with no extra skid entry. The output register is separate, so a channel holds up to FIFO_DEPTH+1 words in flight including the output register.
- All comparisons and next() are computed combinationally from the registered s_i. No multicycle paths.

## Test plan
- Channel 0 correct stream: SEED_BASE=1, one valid word 64'h0000_0000_4082_2041 on channel 0 with out_rdy=1.
  - Required: out_vld after 1 edge with out_data=64'h40822041, out_idx=0.
  - Required: err_cnt=0, word_cnt=1.
- Corruption: 10 correct words on channel 1, with word 5 bit-flipped.
  - Required: err_cnt=1, and words 6..10 still match.
  - Required: 10 words out in order.
- Fairness: all 4 channels valid for 1 cycle, out_rdy=1.
  - Required: out_idx sequence 0,1,2,3 on consecutive cycles.
  - Then channels 1 and 3 valid once: required order 1,3.
- Backpressure/overflow: FIFO_DEPTH=8, out_rdy=0, channel 2 sends 10 words.
  - Required: first word in the output register, 8 buffered, tenth dropped, overflow=4'b0100.
  - After out_rdy=1: exactly 9 words out with stable data during stalls. word_cnt=9.
- Simultaneous errors: channels 0..3 all send wrong words in one cycle.
  - Required: err_cnt += 4.
  - Preload err_cnt near 16'hFFFE through repeated errors: required saturation at 16'hFFFF.
- Reset/clr mid-operation: assert rst_n=0 with words buffered and out_vld=1.
  - Required: out_vld=0 immediately, all counters 0.
  - Next correct stream must restart from seed 1 with no errors. The same check applies for clr=1.

Source files
------------

// File: rtl/cpu_stream_collector.sv
// -----------------------------------------------------------------------------
// cpu_stream_collector
//
// Collects the xorshift64 word streams of NUM_CPUS clients. The block checks
// each arriving word against a per-channel reference generator and buffers it
// in a per-channel FIFO. A round-robin arbiter then merges the FIFOs onto one
// valid/ready stream that carries the source index. Status counters track
// mismatches, delivered words and dropped words.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   clr       synchronous clear of status, FIFOs, arbiter and reference models
//   in_vld    per-channel word strobe (bit i = CPU i), no backpressure
//   in_data   channel i word in bits [64*i+63:64*i]
//   out_vld   merged output word valid
//   out_rdy   downstream ready
//   out_data  merged output word
//   out_idx   source CPU index of out_data
//   err_cnt   saturating count of mismatching words
//   word_cnt  wrapping count of output handshakes
//   overflow  sticky per-channel drop flags
// -----------------------------------------------------------------------------
module cpu_stream_collector #(
    parameter int          NUM_CPUS   = 4,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [63:0] SEED_BASE  = 64'h1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic [NUM_CPUS-1:0]      in_vld,
    input  logic [64*NUM_CPUS-1:0]   in_data,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [63:0]              out_data,
    output logic [3:0]               out_idx,
    output logic [15:0]              err_cnt,
    output logic [31:0]              word_cnt,
    output logic [NUM_CPUS-1:0]      overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    // One xorshift64 step: x ^= x<<13; x ^= x>>7; x ^= x<<17.
    function automatic logic [63:0] xs_next(input logic [63:0] x);
        logic [63:0] t;
        t = x ^ (x << 6'd13);
        t = t ^ (t >> 6'd7);
        t = t ^ (t << 6'd17);
        return t;
    endfunction

    // Reference generator state and FIFO bookkeeping
    logic [63:0]         seed_r   [NUM_CPUS];
    logic [63:0]         mem_r    [NUM_CPUS][FIFO_DEPTH];
    logic [AW-1:0]       wptr_r   [NUM_CPUS];
    logic [AW-1:0]       rptr_r   [NUM_CPUS];
    logic [CW-1:0]       cnt_r    [NUM_CPUS];
    logic [NUM_CPUS-1:0] overflow_r;

    // Arbiter and output stage
    logic [3:0]          rr_r;
    logic                out_vld_r;
    logic [63:0]         out_data_r;
    logic [3:0]          out_idx_r;
    logic [15:0]         err_cnt_r;
    logic [31:0]         word_cnt_r;

    // Combinational helpers
    logic [63:0]         expected_s [NUM_CPUS];
    logic [NUM_CPUS-1:0] mism_s;
    logic [NUM_CPUS-1:0] full_s;
    logic [NUM_CPUS-1:0] empty_s;
    logic [NUM_CPUS-1:0] push_s;
    logic [NUM_CPUS-1:0] pop_vec_s;
    int                  dist_s [NUM_CPUS];
    int                  best_dist_s;
    logic                cand_vld_s;
    logic [3:0]          cand_ch_s;
    logic [63:0]         cand_data_s;
    logic                pop_s;
    logic                hs_s;
    logic [3:0]          rr_next_s;
    logic [4:0]          err_sum_s;
    logic [16:0]         err_tot_s;
    logic [15:0]         err_next_s;

    // Per-channel check, FIFO status and write qualification
    always_comb begin
        mism_s  = {NUM_CPUS{1'b0}};
        full_s  = {NUM_CPUS{1'b0}};
        empty_s = {NUM_CPUS{1'b0}};
        push_s  = {NUM_CPUS{1'b0}};
        for (int j = 0; j < NUM_CPUS; j++) begin
            expected_s[j] = xs_next(seed_r[j]);
            mism_s[j]     = in_vld[j] && (in_data[64*j +: 64] != expected_s[j]);
            // Fullness uses pre-pop occupancy: a push into a full FIFO drops
            // even if the same cycle pops it.
            full_s[j]     = (cnt_r[j] == CW'(FIFO_DEPTH));
            empty_s[j]    = (cnt_r[j] == {CW{1'b0}});
            push_s[j]     = in_vld[j] && !full_s[j];
        end
    end

    // Distance of each channel from the round-robin pointer, wrapping
    always_comb begin
        for (int j = 0; j < NUM_CPUS; j++) begin
            dist_s[j] = (j >= int'(rr_r)) ? (j - int'(rr_r)) : (j + NUM_CPUS - int'(rr_r));
        end
    end

    // Candidate is the non-empty channel closest at or after rr
    always_comb begin
        cand_vld_s  = 1'b0;
        cand_ch_s   = 4'd0;
        best_dist_s = NUM_CPUS;
        for (int j = 0; j < NUM_CPUS; j++) begin
            if (!empty_s[j] && (dist_s[j] < best_dist_s)) begin
                cand_vld_s  = 1'b1;
                cand_ch_s   = 4'(j);
                best_dist_s = dist_s[j];
            end else begin
                best_dist_s = best_dist_s;
            end
        end
    end

    // Head word of the selected channel
    always_comb begin
        cand_data_s = 64'd0;
        for (int j = 0; j < NUM_CPUS; j++) begin
            cand_data_s = (cand_ch_s == 4'(j)) ? mem_r[j][rptr_r[j]] : cand_data_s;
        end
    end

    // Pop decision, handshake and next arbiter pointer
    always_comb begin
        hs_s      = out_vld_r && out_rdy;
        pop_s     = cand_vld_s && (!out_vld_r || out_rdy);
        rr_next_s = (cand_ch_s == 4'(NUM_CPUS - 1)) ? 4'd0 : (cand_ch_s + 4'd1);
        for (int j = 0; j < NUM_CPUS; j++) begin
            pop_vec_s[j] = pop_s && (cand_ch_s == 4'(j));
        end
    end

    // Number of mismatching channels this cycle, added with saturation
    always_comb begin
        err_sum_s = 5'd0;
        for (int j = 0; j < NUM_CPUS; j++) begin
            err_sum_s = err_sum_s + {4'd0, mism_s[j]};
        end
        err_tot_s  = {1'b0, err_cnt_r} + {12'd0, err_sum_s};
        err_next_s = err_tot_s[16] ? 16'hFFFF : err_tot_s[15:0];
    end

    // FIFO storage; contents need no reset because pointers define validity
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CPUS; i++) begin
            if (push_s[i] && !clr) begin
                mem_r[i][wptr_r[i]] <= in_data[64*i +: 64];
            end
        end
    end

    // Reference generators, FIFO pointers/occupancy and overflow flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CPUS; i++) begin
                seed_r[i] <= SEED_BASE + 64'(i);
                wptr_r[i] <= {AW{1'b0}};
                rptr_r[i] <= {AW{1'b0}};
                cnt_r[i]  <= {CW{1'b0}};
            end
            overflow_r <= {NUM_CPUS{1'b0}};
        end else if (clr) begin
            for (int i = 0; i < NUM_CPUS; i++) begin
                seed_r[i] <= SEED_BASE + 64'(i);
                wptr_r[i] <= {AW{1'b0}};
                rptr_r[i] <= {AW{1'b0}};
                cnt_r[i]  <= {CW{1'b0}};
            end
            overflow_r <= {NUM_CPUS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CPUS; i++) begin
                // The generator advances on every valid word, good or bad,
                // so a single corrupt word costs exactly one error.
                if (in_vld[i]) begin
                    seed_r[i] <= expected_s[i];
                end
                if (push_s[i]) begin
                    wptr_r[i] <= wptr_r[i] + AW'(1);
                end
                if (pop_vec_s[i]) begin
                    rptr_r[i] <= rptr_r[i] + AW'(1);
                end
                case ({push_s[i], pop_vec_s[i]})
                    2'b10:   cnt_r[i] <= cnt_r[i] + CW'(1);
                    2'b01:   cnt_r[i] <= cnt_r[i] - CW'(1);
                    default: cnt_r[i] <= cnt_r[i];
                endcase
                if (in_vld[i] && full_s[i]) begin
                    overflow_r[i] <= 1'b1;
                end
            end
        end
    end

    // Output register, arbiter pointer and status counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_r  <= 1'b0;
            out_data_r <= 64'd0;
            out_idx_r  <= 4'd0;
            rr_r       <= 4'd0;
            err_cnt_r  <= 16'd0;
            word_cnt_r <= 32'd0;
        end else if (clr) begin
            out_vld_r  <= 1'b0;
            rr_r       <= 4'd0;
            err_cnt_r  <= 16'd0;
            word_cnt_r <= 32'd0;
        end else begin
            if (pop_s) begin
                out_vld_r  <= 1'b1;
                out_data_r <= cand_data_s;
                out_idx_r  <= cand_ch_s;
                rr_r       <= rr_next_s;
            end else if (hs_s) begin
                out_vld_r  <= 1'b0;
            end
            if (hs_s) begin
                word_cnt_r <= word_cnt_r + 32'd1;
            end
            err_cnt_r <= err_next_s;
        end
    end

    assign out_vld  = out_vld_r;
    assign out_data = out_data_r;
    assign out_idx  = out_idx_r;
    assign err_cnt  = err_cnt_r;
    assign word_cnt = word_cnt_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_cpu_stream_collector.sv
// -----------------------------------------------------------------------------
// tb_cpu_stream_collector
//
// Self-checking bench for cpu_stream_collector. A queue-based behavioural
// model (per-channel generator state, FIFO queues, round-robin pick, output
// register) advances once per clock and is compared against the DUT after
// every edge. Directed sections pin literal values from the test plan;
// a randomized section exercises mixed traffic, stalls, errors and clears.
// -----------------------------------------------------------------------------
module tb_cpu_stream_collector;

    localparam int          NUM   = 4;
    localparam int          DEPTH = 8;
    localparam logic [63:0] SEED  = 64'h1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 clr;
    logic [NUM-1:0]       in_vld;
    logic [64*NUM-1:0]    in_data;
    logic                 out_vld;
    logic                 out_rdy;
    logic [63:0]          out_data;
    logic [3:0]           out_idx;
    logic [15:0]          err_cnt;
    logic [31:0]          word_cnt;
    logic [NUM-1:0]       overflow;

    int  errors = 0;
    int  checks = 0;
    bit  chk_en = 1'b0;

    // Client generators
    logic [63:0] g_seed [NUM];

    // Behavioural model
    logic [63:0] m_seed [NUM];
    logic [63:0] m_q    [NUM][$];
    bit          m_vld;
    logic [63:0] m_data;
    int          m_idx;
    int          m_rr;
    int          m_err;
    logic [31:0] m_words;
    logic [NUM-1:0] m_ovf;

    cpu_stream_collector #(
        .NUM_CPUS   (NUM),
        .FIFO_DEPTH (DEPTH),
        .SEED_BASE  (SEED)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_idx  (out_idx),
        .err_cnt  (err_cnt),
        .word_cnt (word_cnt),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] xs(input logic [63:0] x);
        logic [63:0] t;
        t = x;
        t = t ^ (t << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic gen_reset();
        for (int i = 0; i < NUM; i++) g_seed[i] = SEED + 64'(i);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM; i++) begin
            m_seed[i] = SEED + 64'(i);
            m_q[i].delete();
        end
        m_vld   = 1'b0;
        m_data  = 64'd0;
        m_idx   = 0;
        m_rr    = 0;
        m_err   = 0;
        m_words = 32'd0;
        m_ovf   = '0;
    endtask

    // One clock of the model, using the inputs the DUT samples at the next edge
    task automatic model_step();
        int   cand;
        bit   hs;
        int   pre_size [NUM];
        logic [63:0] e;
        logic [63:0] w;
        if (!rst_n || clr) begin
            model_reset();
            return;
        end
        hs   = m_vld && out_rdy;
        cand = -1;
        for (int k = 0; k < NUM; k++) begin
            int ch;
            ch = (m_rr + k) % NUM;
            if (cand < 0 && m_q[ch].size() > 0) cand = ch;
        end
        for (int i = 0; i < NUM; i++) pre_size[i] = m_q[i].size();
        if (cand >= 0 && (!m_vld || out_rdy)) begin
            m_data = m_q[cand].pop_front();
            m_idx  = cand;
            m_vld  = 1'b1;
            m_rr   = (cand + 1) % NUM;
        end else if (hs) begin
            m_vld = 1'b0;
        end
        if (hs) m_words = m_words + 32'd1;
        for (int i = 0; i < NUM; i++) begin
            if (in_vld[i]) begin
                w = in_data[64*i +: 64];
                e = xs(m_seed[i]);
                if (w != e) m_err = (m_err >= 65535) ? 65535 : m_err + 1;
                m_seed[i] = e;
                if (pre_size[i] >= DEPTH) m_ovf[i] = 1'b1;
                else m_q[i].push_back(w);
            end
        end
    endtask

    // Advance one clock edge, then compare the DUT against the model
    task automatic tick();
        logic        st;
        logic [63:0] sd;
        logic [3:0]  si;
        st = rst_n && !clr && out_vld && !out_rdy;
        sd = out_data;
        si = out_idx;
        model_step();
        @(negedge clk);
        if (chk_en) begin
            chk("m_out_vld", 64'(out_vld), 64'(m_vld));
            if (m_vld) begin
                chk("m_out_data", out_data, m_data);
                chk("m_out_idx", 64'(out_idx), 64'(m_idx));
            end
            chk("m_err_cnt", 64'(err_cnt), 64'(m_err));
            chk("m_word_cnt", 64'(word_cnt), 64'(m_words));
            chk("m_overflow", 64'(overflow), 64'(m_ovf));
            if (st) begin
                chk("stall_vld", 64'(out_vld), 64'd1);
                chk("stall_data", out_data, sd);
                chk("stall_idx", 64'(out_idx), 64'(si));
            end
        end
    endtask

    task automatic set_inputs(input logic [NUM-1:0] v, input logic [NUM-1:0] bad);
        for (int i = 0; i < NUM; i++) begin
            logic [63:0] w;
            if (v[i]) begin
                g_seed[i] = xs(g_seed[i]);
                w = g_seed[i];
                if (bad[i]) w = w ^ (64'h1 << $urandom_range(63, 0));
            end else begin
                w = {$urandom, $urandom};
            end
            in_data[64*i +: 64] = w;
        end
        in_vld = v;
    endtask

    task automatic idle();
        in_vld = '0;
        for (int i = 0; i < NUM; i++) in_data[64*i +: 64] = {$urandom, $urandom};
    endtask

    initial begin
        int          got;
        logic [63:0] exp_words [10];

        rst_n   = 1'b0;
        clr     = 1'b0;
        out_rdy = 1'b0;
        in_vld  = '0;
        in_data = '0;
        gen_reset();
        model_reset();
        tick();
        tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Reset state
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_word_cnt", 64'(word_cnt), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);

        // Channel 0 single correct word
        out_rdy = 1'b1;
        set_inputs(4'b0001, 4'b0000);
        chk("t1_stim", in_data[63:0], 64'h0000_0000_4082_2041);
        tick();
        chk("t1_vld_edge_k", 64'(out_vld), 64'd0);
        idle();
        tick();
        chk("t1_vld", 64'(out_vld), 64'd1);
        chk("t1_data", out_data, 64'h40822041);
        chk("t1_idx", 64'(out_idx), 64'd0);
        chk("t1_err", 64'(err_cnt), 64'd0);
        tick();
        chk("t1_words", 64'(word_cnt), 64'd1);

        // Channel 1: ten words, the fifth corrupted
        for (int w = 1; w <= 10; w++) begin
            set_inputs(4'b0010, (w == 5) ? 4'b0010 : 4'b0000);
            tick();
            if (w == 5) chk("t2_err_at5", 64'(err_cnt), 64'd1);
        end
        idle();
        repeat (3) tick();
        chk("t2_err", 64'(err_cnt), 64'd1);
        chk("t2_words", 64'(word_cnt), 64'd11);

        // Fairness after a clear
        clr = 1'b1;
        tick();
        clr = 1'b0;
        gen_reset();
        chk("clr_err", 64'(err_cnt), 64'd0);
        chk("clr_words", 64'(word_cnt), 64'd0);
        set_inputs(4'b1111, 4'b0000);
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_vld", 64'(out_vld), 64'd1);
            chk("t3_idx", 64'(out_idx), 64'(k));
        end
        set_inputs(4'b1010, 4'b0000);
        tick();
        idle();
        tick();
        chk("t3_idx_a", 64'(out_idx), 64'd1);
        tick();
        chk("t3_idx_b", 64'(out_idx), 64'd3);
        tick();
        chk("t3_vld_end", 64'(out_vld), 64'd0);

        // Backpressure and overflow on channel 2
        clr = 1'b1;
        tick();
        clr = 1'b0;
        gen_reset();
        out_rdy = 1'b0;
        for (int w = 0; w < 10; w++) begin
            set_inputs(4'b0100, 4'b0000);
            exp_words[w] = g_seed[2];
            tick();
        end
        idle();
        tick();
        chk("t4_overflow", 64'(overflow), 64'b0100);
        chk("t4_vld", 64'(out_vld), 64'd1);
        chk("t4_idx", 64'(out_idx), 64'd2);
        chk("t4_first", out_data, exp_words[0]);
        got = 0;
        for (int c = 0; c < 80; c++) begin
            out_rdy = (c >= 60) ? 1'b1 : 1'($urandom_range(1, 0));
            if (out_vld && out_rdy) begin
                if (got < 10) chk("t4_word", out_data, exp_words[got]);
                got++;
            end
            tick();
        end
        chk("t4_count", 64'(got), 64'd9);
        chk("t4_words", 64'(word_cnt), 64'd9);

        // Simultaneous errors and saturation
        clr = 1'b1;
        tick();
        clr = 1'b0;
        gen_reset();
        out_rdy = 1'b1;
        set_inputs(4'b1111, 4'b1111);
        tick();
        chk("t5_err4", 64'(err_cnt), 64'd4);
        for (int c = 0; c < 16382; c++) begin
            set_inputs(4'b1111, 4'b1111);
            tick();
        end
        set_inputs(4'b0011, 4'b0011);
        tick();
        chk("t5_fffe", 64'(err_cnt), 64'hFFFE);
        set_inputs(4'b1111, 4'b1111);
        tick();
        chk("t5_sat", 64'(err_cnt), 64'hFFFF);
        set_inputs(4'b0001, 4'b0001);
        tick();
        chk("t5_sat_hold", 64'(err_cnt), 64'hFFFF);
        idle();
        repeat (40) tick();

        // Asynchronous reset mid-stream
        clr = 1'b1;
        tick();
        clr = 1'b0;
        gen_reset();
        out_rdy = 1'b1;
        set_inputs(4'b1111, 4'b0001);
        tick();
        idle();
        tick();
        tick();
        out_rdy = 1'b0;
        set_inputs(4'b1111, 4'b0000);
        tick();
        idle();
        tick();
        chk("t6_pre_vld", 64'(out_vld), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_vld", 64'(out_vld), 64'd0);
        chk("t6_data", out_data, 64'd0);
        chk("t6_err", 64'(err_cnt), 64'd0);
        chk("t6_words", 64'(word_cnt), 64'd0);
        chk("t6_ovf", 64'(overflow), 64'd0);
        model_reset();
        gen_reset();
        tick();
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        set_inputs(4'b0001, 4'b0000);
        tick();
        idle();
        tick();
        chk("t6_restart_vld", 64'(out_vld), 64'd1);
        chk("t6_restart_data", out_data, 64'h40822041);
        chk("t6_restart_idx", 64'(out_idx), 64'd0);
        tick();
        chk("t6_restart_err", 64'(err_cnt), 64'd0);

        // Synchronous clear mid-stream
        out_rdy = 1'b0;
        for (int w = 0; w < 10; w++) begin
            set_inputs(4'b0001, (w == 0) ? 4'b0001 : 4'b0000);
            tick();
        end
        chk("t7_pre_ovf", 64'(overflow), 64'b0001);
        chk("t7_pre_err", 64'(err_cnt), 64'd1);
        clr = 1'b1;
        set_inputs(4'b1111, 4'b1111);
        tick();
        clr = 1'b0;
        idle();
        gen_reset();
        chk("t7_vld", 64'(out_vld), 64'd0);
        chk("t7_err", 64'(err_cnt), 64'd0);
        chk("t7_words", 64'(word_cnt), 64'd0);
        chk("t7_ovf", 64'(overflow), 64'd0);
        out_rdy = 1'b1;
        set_inputs(4'b0001, 4'b0000);
        tick();
        idle();
        tick();
        chk("t7_restart_data", out_data, 64'h40822041);
        chk("t7_restart_idx", 64'(out_idx), 64'd0);
        tick();
        chk("t7_restart_err", 64'(err_cnt), 64'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [NUM-1:0] v;
            logic [NUM-1:0] bad;
            v = ((c % 600) < 300) ? (NUM'($urandom) & NUM'($urandom)) : (NUM'($urandom) | NUM'($urandom));
            bad = '0;
            for (int i = 0; i < NUM; i++) begin
                if ($urandom_range(31, 0) == 0) bad[i] = 1'b1;
            end
            out_rdy = ($urandom_range(3, 0) != 0);
            if ($urandom_range(199, 0) == 0) begin
                clr = 1'b1;
                set_inputs(v, bad);
                tick();
                clr = 1'b0;
                gen_reset();
            end else begin
                set_inputs(v, bad);
                tick();
            end
        end
        idle();
        out_rdy = 1'b1;
        repeat (50) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
